// File: rtl/sim_supervisor_if.sv
// Monitor-to-supervisor bundle: per-channel commit/halt/error strobes and the run budget
// flow in, while the DUT reset, run state and sticky status flow back out.
interface sim_supervisor_if #(
    parameter int CHANNELS  = 8,
    parameter int TIMEOUT_W = 32
);
    logic [TIMEOUT_W-1:0] cfg_timeout;
    logic [CHANNELS-1:0]  commit_valid;
    logic [CHANNELS-1:0]  halt;
    logic [CHANNELS-1:0]  error;
    logic                 dut_rst;
    logic [2:0]           state;
    logic                 done;
    logic                 timed_out;
    logic                 hung;
    logic                 err_seen;
    logic [TIMEOUT_W-1:0] cycle_count;
    logic [31:0]          commit_count;
    logic [CHANNELS-1:0]  err_chan;

    modport slave (
        input  cfg_timeout, commit_valid, halt, error,
        output dut_rst, state, done, timed_out, hung, err_seen,
               cycle_count, commit_count, err_chan
    );

    modport master (
        output cfg_timeout, commit_valid, halt, error,
        input  dut_rst, state, done, timed_out, hung, err_seen,
               cycle_count, commit_count, err_chan
    );
endinterface

// File: rtl/sim_supervisor.sv
// Simulation supervisor: generates the DUT reset, then watches commit/halt/error channels
// and ends the run in DONE or FAIL on halt, error (via DRAIN), timeout or hang.
module sim_supervisor #(
    parameter int CHANNELS     = 8,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT_W    = 32,
    parameter int HANG_CYCLES  = 4096,
    parameter int HALT_MODE    = 0,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sim_supervisor_if.slave bus
);

    typedef enum logic [2:0] {
        RESET_GEN = 3'd0,
        RUN       = 3'd1,
        DRAIN     = 3'd2,
        DONE      = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [7:0]  RST_LAST   = 8'(RESET_CYCLES - 1);
    localparam logic [31:0] HANG_LAST  = 32'(HANG_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE = TIMEOUT_W'(1);

    state_t               state_q;
    logic                 dut_rst_q;
    logic                 done_q;
    logic                 timed_out_q;
    logic                 hung_q;
    logic                 err_seen_q;
    logic [TIMEOUT_W-1:0] cycle_count_q;
    logic [31:0]          commit_count_q;
    logic [CHANNELS-1:0]  err_chan_q;
    logic [CHANNELS-1:0]  halted_q;
    logic [7:0]           rst_cnt_q;
    logic [31:0]          hang_cnt_q;
    logic [31:0]          drain_cnt_q;
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 tmo_en_q;

    logic [5:0] n_commit;
    logic       any_commit;
    logic       any_err;
    logic       halt_cond;
    logic       tmo_hit;
    logic       hang_hit;

    function automatic logic [5:0] popcount(input logic [CHANNELS-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TMO_ONE;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [5:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {27'd0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_comb begin
        n_commit   = popcount(bus.commit_valid);
        any_commit = |bus.commit_valid;
        any_err    = |bus.error;
        halt_cond  = 1'b0;
        if (HALT_MODE == 0) begin
            halt_cond = bus.halt[0];
        end else if (HALT_MODE == 1) begin
            halt_cond = |bus.halt;
        end else begin
            // This cycle's halts count toward the all-halted condition immediately.
            halt_cond = &(halted_q | bus.halt);
        end
        tmo_hit  = tmo_en_q && (tmo_cnt_q == TMO_ONE);
        hang_hit = !any_commit && (hang_cnt_q == HANG_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RESET_GEN;
            dut_rst_q      <= 1'b1;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
            hung_q         <= 1'b0;
            err_seen_q     <= 1'b0;
            cycle_count_q  <= '0;
            commit_count_q <= '0;
            err_chan_q     <= '0;
            halted_q       <= '0;
            rst_cnt_q      <= '0;
            hang_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            tmo_cnt_q      <= bus.cfg_timeout;
            tmo_en_q       <= |bus.cfg_timeout;
        end else begin
            case (state_q)
                RESET_GEN: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q   <= RUN;
                        dut_rst_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    cycle_count_q  <= sat_inc(cycle_count_q);
                    commit_count_q <= sat_add32(commit_count_q, n_commit);
                    hang_cnt_q     <= any_commit ? 32'd0 : hang_cnt_q + 32'd1;
                    halted_q       <= halted_q | bus.halt;
                    if (tmo_en_q) begin
                        tmo_cnt_q <= tmo_cnt_q - TMO_ONE;
                    end
                    // Exit causes in priority order; only one status flag is ever raised.
                    if (any_err) begin
                        state_q     <= DRAIN;
                        err_seen_q  <= 1'b1;
                        err_chan_q  <= err_chan_q | bus.error;
                        drain_cnt_q <= '0;
                    end else if (halt_cond) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q     <= FAIL;
                        timed_out_q <= 1'b1;
                    end else if (hang_hit) begin
                        state_q <= FAIL;
                        hung_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    err_chan_q <= err_chan_q | bus.error;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= FAIL;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign bus.dut_rst      = dut_rst_q;
    assign bus.state        = state_q;
    assign bus.done         = done_q;
    assign bus.timed_out    = timed_out_q;
    assign bus.hung         = hung_q;
    assign bus.err_seen     = err_seen_q;
    assign bus.cycle_count  = cycle_count_q;
    assign bus.commit_count = commit_count_q;
    assign bus.err_chan     = err_chan_q;

endmodule

// File: tb/tb_sim_supervisor.sv
// Bench for sim_supervisor: three instances (halt modes 0/1/2) driven by the same directed
// and random runs, each compared every cycle against a run-outcome reference model.
module tb_sim_supervisor;
    localparam int CH   = 8;
    localparam int TW   = 32;
    localparam int HC   = 16;
    localparam int RC   = 2;
    localparam int DC   = 2;
    localparam int MAXN = 64;

    typedef struct packed {
        logic          dut_rst;
        logic [2:0]    state;
        logic          done;
        logic          timed_out;
        logic          hung;
        logic          err_seen;
        logic [TW-1:0] cyc;
        logic [31:0]   cc;
        logic [CH-1:0] ec;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int            n_cyc;
    logic [31:0]   s_tmo;
    logic [CH-1:0] s_cv [0:MAXN];
    logic [CH-1:0] s_h  [0:MAXN];
    logic [CH-1:0] s_e  [0:MAXN];

    always #5 clk = ~clk;

    sim_supervisor_if #(.CHANNELS(CH), .TIMEOUT_W(TW)) if0 ();
    sim_supervisor_if #(.CHANNELS(CH), .TIMEOUT_W(TW)) if1 ();
    sim_supervisor_if #(.CHANNELS(CH), .TIMEOUT_W(TW)) if2 ();

    sim_supervisor #(.CHANNELS(CH), .RESET_CYCLES(RC), .TIMEOUT_W(TW), .HANG_CYCLES(HC),
                     .HALT_MODE(0), .DRAIN_CYCLES(DC)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sim_supervisor #(.CHANNELS(CH), .RESET_CYCLES(RC), .TIMEOUT_W(TW), .HANG_CYCLES(HC),
                     .HALT_MODE(1), .DRAIN_CYCLES(DC)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sim_supervisor #(.CHANNELS(CH), .RESET_CYCLES(RC), .TIMEOUT_W(TW), .HANG_CYCLES(HC),
                     .HALT_MODE(2), .DRAIN_CYCLES(DC)) u2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic drive(input logic [CH-1:0] cv, input logic [CH-1:0] h, input logic [CH-1:0] e);
        if0.commit_valid = cv; if0.halt = h; if0.error = e;
        if1.commit_valid = cv; if1.halt = h; if1.error = e;
        if2.commit_valid = cv; if2.halt = h; if2.error = e;
    endtask

    task automatic set_tmo(input logic [TW-1:0] t);
        if0.cfg_timeout = t;
        if1.cfg_timeout = t;
        if2.cfg_timeout = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int m, input int k,
                       input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s u%0d step %0d observed=%0h expected=%0h", tag, m, k, obs, exp);
        end
    endtask

    function automatic snap_t grab(input int m);
        snap_t x;
        if (m == 0)
            x = {if0.dut_rst, if0.state, if0.done, if0.timed_out, if0.hung, if0.err_seen,
                 if0.cycle_count, if0.commit_count, if0.err_chan};
        else if (m == 1)
            x = {if1.dut_rst, if1.state, if1.done, if1.timed_out, if1.hung, if1.err_seen,
                 if1.cycle_count, if1.commit_count, if1.err_chan};
        else
            x = {if2.dut_rst, if2.state, if2.done, if2.timed_out, if2.hung, if2.err_seen,
                 if2.cycle_count, if2.commit_count, if2.err_chan};
        return x;
    endfunction

    // First RUN cycle (1-based) at which the run ends for a halt mode, and why:
    // 1 error, 2 halt, 3 timeout, 4 hang; 0 if the run never ends within n_cyc.
    function automatic void find_end(input int mode, output int e_idx, output int why);
        logic [CH-1:0] hacc;
        int            streak;
        logic          hc;
        e_idx = 0; why = 0; hacc = '0; streak = 0;
        for (int j = 1; j <= n_cyc; j++) begin
            if (e_idx == 0) begin
                hacc   = hacc | s_h[j];
                streak = (s_cv[j] == '0) ? streak + 1 : 0;
                hc = (mode == 0) ? s_h[j][0] : (mode == 1) ? (s_h[j] != '0) : (&hacc);
                if (s_e[j] != '0)                           begin e_idx = j; why = 1; end
                else if (hc)                                begin e_idx = j; why = 2; end
                else if (s_tmo != 0 && j == int'(s_tmo))    begin e_idx = j; why = 3; end
                else if (streak == HC)                      begin e_idx = j; why = 4; end
            end
        end
    endfunction

    function automatic snap_t model(input int mode, input int k);
        snap_t x;
        int    e, why, lim, top;
        x = '0;
        find_end(mode, e, why);
        lim = (e != 0 && k > e) ? e : k;
        x.cyc = TW'(lim);
        for (int j = 1; j <= lim; j++) x.cc = x.cc + 32'($countones(s_cv[j]));
        x.state = 3'd1;
        if (e != 0 && k >= e) begin
            case (why)
                1: begin
                    x.err_seen = 1'b1;
                    x.state    = (k >= e + DC) ? 3'd4 : 3'd2;
                    top        = (k < e + DC) ? k : e + DC;
                    for (int j = e; j <= top; j++) x.ec = x.ec | s_e[j];
                end
                2:       begin x.done = 1'b1;      x.state = 3'd3; end
                3:       begin x.timed_out = 1'b1; x.state = 3'd4; end
                default: begin x.hung = 1'b1;      x.state = 3'd4; end
            endcase
        end
        return x;
    endfunction

    function automatic snap_t reset_snap();
        snap_t x;
        x = '0;
        x.dut_rst = 1'b1;
        return x;
    endfunction

    task automatic cmp(input int m, input int k, input snap_t exp);
        snap_t obs;
        obs = grab(m);
        chk("dut_rst",      m, k, 64'(obs.dut_rst),   64'(exp.dut_rst));
        chk("state",        m, k, 64'(obs.state),     64'(exp.state));
        chk("done",         m, k, 64'(obs.done),      64'(exp.done));
        chk("timed_out",    m, k, 64'(obs.timed_out), 64'(exp.timed_out));
        chk("hung",         m, k, 64'(obs.hung),      64'(exp.hung));
        chk("err_seen",     m, k, 64'(obs.err_seen),  64'(exp.err_seen));
        chk("cycle_count",  m, k, 64'(obs.cyc),       64'(exp.cyc));
        chk("commit_count", m, k, 64'(obs.cc),        64'(exp.cc));
        chk("err_chan",     m, k, 64'(obs.ec),        64'(exp.ec));
    endtask

    task automatic check_all(input int k, input bit in_reset);
        for (int m = 0; m < 3; m++) cmp(m, k, in_reset ? reset_snap() : model(m, k));
    endtask

    task automatic clr(input int n, input logic [31:0] t);
        n_cyc = n;
        s_tmo = t;
        for (int j = 0; j <= MAXN; j++) begin
            s_cv[j] = '0; s_h[j] = '0; s_e[j] = '0;
        end
    endtask

    // Reset, release, then play s_* for n_cyc RUN cycles. Garbage on the monitor inputs
    // during reset generation and a changed cfg_timeout after release must have no effect.
    task automatic run_scenario();
        rst = 1'b0;
        set_tmo(s_tmo);
        for (int i = 0; i < 3; i++) begin
            drive(CH'($urandom), CH'($urandom), CH'($urandom));
            tick();
            check_all(-1, 1'b1);
        end
        rst = 1'b1;
        set_tmo(TW'($urandom_range(1, 3)));
        for (int i = 0; i < RC; i++) begin
            drive(CH'($urandom), CH'($urandom), CH'($urandom));
            tick();
            check_all(0, (i < RC - 1));
        end
        for (int k = 1; k <= n_cyc; k++) begin
            drive(s_cv[k], s_h[k], s_e[k]);
            tick();
            check_all(k, 1'b0);
        end
    endtask

    initial begin
        int dens;

        // Halt on channel 0 after ten double-commit cycles.
        clr(11, 0);
        for (int k = 1; k <= 10; k++) s_cv[k] = 8'h03;
        s_h[11] = 8'h01;
        run_scenario();
        chk("halt_state",  0, 11, 64'(if0.state),        64'd3);
        chk("halt_done",   0, 11, 64'(if0.done),         64'd1);
        chk("halt_commit", 0, 11, 64'(if0.commit_count), 64'd20);
        chk("halt_cycles", 0, 11, 64'(if0.cycle_count),  64'd11);

        // Timeout of 5 with commits every cycle.
        clr(7, 5);
        for (int k = 1; k <= 7; k++) s_cv[k] = 8'h81;
        run_scenario();
        chk("tmo_state", 0, 7, 64'(if0.state),     64'd4);
        chk("tmo_flag",  0, 7, 64'(if0.timed_out), 64'd1);
        chk("tmo_hung",  0, 7, 64'(if0.hung),      64'd0);

        // Error beats halt in the same cycle; halt during DRAIN is ignored.
        clr(6, 0);
        for (int k = 1; k <= 6; k++) s_cv[k] = 8'h01;
        s_h[3] = 8'h01; s_e[3] = 8'h04; s_h[4] = 8'hFF;
        run_scenario();
        chk("prio_state",    0, 6, 64'(if0.state),    64'd4);
        chk("prio_done",     0, 6, 64'(if0.done),     64'd0);
        chk("prio_err_seen", 0, 6, 64'(if0.err_seen), 64'd1);
        chk("prio_err_chan", 0, 6, 64'(if0.err_chan), 64'h04);

        // All-halt: one channel per cycle, DONE on the eighth for mode 2.
        clr(9, 0);
        for (int k = 1; k <= 9; k++) s_cv[k] = 8'h01;
        for (int k = 1; k <= 8; k++) s_h[k] = 8'(1 << (k - 1));
        run_scenario();
        chk("allhalt_state",  2, 9, 64'(if2.state),       64'd3);
        chk("allhalt_cycles", 2, 9, 64'(if2.cycle_count), 64'd8);

        // Hang after 16 commit-free cycles.
        clr(18, 0);
        run_scenario();
        chk("hang_flag",   0, 18, 64'(if0.hung),        64'd1);
        chk("hang_cycles", 0, 18, 64'(if0.cycle_count), 64'd16);

        // Timeout and hang on the same cycle: timeout wins.
        clr(17, 16);
        run_scenario();
        chk("tmo_vs_hang_tmo",  0, 17, 64'(if0.timed_out), 64'd1);
        chk("tmo_vs_hang_hung", 0, 17, 64'(if0.hung),      64'd0);

        // Reset asserted while in DRAIN clears everything on the next edge.
        clr(3, 0);
        for (int k = 1; k <= 3; k++) s_cv[k] = 8'h01;
        s_e[2] = 8'h10;
        run_scenario();
        chk("drain_state", 0, 3, 64'(if0.state), 64'd2);
        rst = 1'b0;
        tick();
        check_all(-1, 1'b1);

        // Randomized runs with per-run commit density and sparse halts/errors.
        for (int r = 0; r < 30; r++) begin
            clr($urandom_range(4, 60), ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 50)));
            dens = $urandom_range(0, 4);
            for (int k = 1; k <= n_cyc; k++) begin
                s_cv[k] = (int'($urandom_range(0, 3)) < dens) ? CH'($urandom) : '0;
                s_h[k]  = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
                s_e[k]  = ($urandom_range(0, 24) == 0) ? CH'(1 << $urandom_range(0, CH - 1)) : '0;
            end
            run_scenario();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sim_supervisor.md
SIM_SUPERVISOR -- requirements
Module: sim_supervisor

Interface
REQ-001 Parameter CHANNELS, default 8: number of monitored commit/halt/error channels (1..32).
REQ-002 Parameter RESET_CYCLES, default 2: cycles for which dut_rst is held after rst deasserts (1..255).
REQ-003 Parameter TIMEOUT_W, default 32: width of the timeout and cycle counters.
REQ-004 Parameter HANG_CYCLES, default 4096: the limit on consecutive commit-free RUN cycles before a hang is declared.
REQ-005 Parameter HALT_MODE, default 0: 0 = halt on channel 0 only, 1 = halt on any channel, 2 = halt when all channels have halted (sticky per channel).
REQ-006 Parameter DRAIN_CYCLES, default 2: cycles spent in DRAIN after an error before entering FAIL.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 cfg_timeout  in  TIMEOUT_W  run budget in cycles, sampled on the last rst-low cycle; 0 disables the timeout.
REQ-010 commit_valid  in  CHANNELS  per-channel retire strobe.
REQ-011 halt  in  CHANNELS  per-channel halt indication.
REQ-012 error  in  CHANNELS  per-channel error indication (memory model or monitor).
REQ-013 dut_rst  out  1  active-high reset to the DUT.
REQ-014 state  out  3  encoding: RESET_GEN=0, RUN=1, DRAIN=2, DONE=3, FAIL=4.
REQ-015 done, timed_out, hung, err_seen  out  1 each  sticky status flags.
REQ-016 cycle_count  out  TIMEOUT_W  number of RUN cycles elapsed.
REQ-017 commit_count  out  32  total retirements, saturating.
REQ-018 err_chan  out  CHANNELS  sticky OR of all error bits seen in RUN and DRAIN.

Function
REQ-019 RESET_GEN: dut_rst=1; an internal counter counts RESET_CYCLES cycles, then the FSM moves to RUN and dut_rst=0 in the same edge.
REQ-020 RUN: cycle_count increments by 1 per cycle, saturating at all-ones.
REQ-021 RUN: commit_count adds popcount(commit_valid) each cycle, saturating at 2^32-1.
REQ-022 RUN: the timeout down-counter is loaded with cfg_timeout; it decrements each RUN cycle; reaching 0 with cfg_timeout!=0 enters FAIL and sets timed_out.
REQ-023 RUN: the hang counter clears on any commit_valid bit; otherwise it increments; reaching HANG_CYCLES enters FAIL and sets hung.
REQ-024 HALT_MODE 2: per-channel halted bits are sticky; the halt condition is true when all bits are set, including the current cycle's inputs.
REQ-025 RUN transitions: a halt condition enters DONE and sets done; any error bit enters DRAIN and sets err_seen.
REQ-026 Same-cycle priority in RUN: error > halt > timeout > hang; exactly one flag is set per run.
REQ-027 DRAIN: err_chan keeps accumulating; after DRAIN_CYCLES cycles the FSM enters FAIL; halt is ignored during DRAIN.
REQ-028 DONE and FAIL are terminal; all counters and flags hold until rst; dut_rst stays 0.
REQ-029 commit, halt and error inputs are ignored while in RESET_GEN.

Reset
REQ-030 rst=0 at a rising edge forces state=RESET_GEN, dut_rst=1, all flags=0, cycle_count=0, commit_count=0, err_chan=0, hang and halted bits=0, and reloads the timeout from cfg_timeout, from any state including mid-RUN and mid-DRAIN.
REQ-031 After rst rises, dut_rst stays 1 for exactly RESET_CYCLES cycles.

Verification
REQ-032 Reset sequence: RESET_CYCLES=2, rst low 3 cycles then high -> dut_rst=1 for exactly 2 edges after release, then state=RUN.
REQ-033 Halt: HALT_MODE=0, 10 RUN cycles with commit_valid=8'h03 each, then halt=8'h01 -> state=DONE, done=1, commit_count=20, cycle_count=11.
REQ-034 Timeout: cfg_timeout=5, no halt, commits every cycle -> after 5 RUN cycles state=FAIL, timed_out=1, hung=0.
REQ-035 Priority: halt=8'h01 and error=8'h04 in the same cycle -> state=DRAIN, then FAIL 2 cycles later; done=0, err_seen=1, err_chan=8'h04.
REQ-036 All-halt and hang: HALT_MODE=2, halts arrive one channel per cycle over 8 cycles -> DONE on the 8th; separately, HANG_CYCLES=16 with no commits -> FAIL, hung=1 after 16 RUN cycles.
REQ-037 Mid-run reset: rst=0 during DRAIN -> next edge state=RESET_GEN with all flags and counters cleared.
